// File: rtl/shift_sequencer.sv
// Multi-cycle shifter: moves at most MAX_STEP bit positions per cycle and
// presents the result under a valid/ready handshake.
module shift_sequencer #(
  parameter int WIDTH    = 32,
  parameter int SHW      = 5,
  parameter int MAX_STEP = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] operand,
  input  logic [SHW-1:0]   shamt,
  input  logic [1:0]       alusel,
  output logic             busy,
  output logic             result_valid,
  input  logic             result_ready,
  output logic [WIDTH-1:0] result
);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_e;

  localparam logic [SHW-1:0] STEP_MAX = SHW'(MAX_STEP);

  state_e           state_q;
  logic [WIDTH-1:0] work_q;
  logic [WIDTH-1:0] work_d;
  logic [SHW-1:0]   rem_q;
  logic [SHW-1:0]   step;
  logic [1:0]       sel_q;
  logic             last;
  logic             rdy_q;
  logic             busy_q;
  logic             vld_q;

  always_comb begin
    last   = (rem_q <= STEP_MAX);
    step   = last ? rem_q : STEP_MAX;
    work_d = work_q;
    unique case (sel_q)
      2'b00:   work_d = work_q << step;
      2'b01:   work_d = work_q >> step;
      2'b10:   work_d = WIDTH'($signed(work_q) >>> step);
      default: work_d = work_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      work_q  <= '0;
      rem_q   <= '0;
      sel_q   <= '0;
      rdy_q   <= 1'b1;
      busy_q  <= 1'b0;
      vld_q   <= 1'b0;
    end else if (flush) begin
      state_q <= IDLE;
      work_q  <= '0;
      rem_q   <= '0;
      rdy_q   <= 1'b1;
      busy_q  <= 1'b0;
      vld_q   <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start_valid) begin
            work_q <= operand;
            rem_q  <= shamt;
            sel_q  <= alusel;
            rdy_q  <= 1'b0;
            busy_q <= 1'b1;
            // zero shift and pass-through skip the iteration entirely
            if (shamt == '0 || alusel == 2'b11) begin
              state_q <= DONE;
              vld_q   <= 1'b1;
            end else begin
              state_q <= SHIFT;
            end
          end
        end
        SHIFT: begin
          work_q <= work_d;
          rem_q  <= rem_q - step;
          if (last) begin
            state_q <= DONE;
            vld_q   <= 1'b1;
          end
        end
        DONE: begin
          if (result_ready) begin
            state_q <= IDLE;
            vld_q   <= 1'b0;
            busy_q  <= 1'b0;
            rdy_q   <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          vld_q   <= 1'b0;
          busy_q  <= 1'b0;
          rdy_q   <= 1'b1;
        end
      endcase
    end
  end

  assign start_ready  = rdy_q;
  assign busy         = busy_q;
  assign result_valid = vld_q;
  assign result       = work_q;

endmodule
